// File: rtl/funnel_rr_buffered.sv
// N-to-1 funnel: per-channel FIFOs drained round-robin into one registered, tagged output.
// Optional per-channel beat counters are built when FUNNEL_COUNT_EN is defined.
module funnel_rr_buffered #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int DEPTH = 4,
  localparam int TAGW = $clog2(NCH)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NCH-1:0]       in_enq__ENA,
  input  logic [NCH*WIDTH-1:0] in_enq_v,
  output logic [NCH-1:0]       in_enq__RDY,
  output logic                 out_enq__ENA,
  output logic [WIDTH-1:0]     out_enq_v,
  output logic [TAGW-1:0]      out_enq_tag,
  input  logic                 out_enq__RDY
`ifdef FUNNEL_COUNT_EN
  ,
  input  logic [TAGW-1:0]      cnt_sel,
  output logic [15:0]          cnt_value
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q    [NCH][DEPTH];
  logic [AW:0]      wr_ptr_q [NCH];
  logic [AW:0]      wr_ptr_d [NCH];
  logic [AW:0]      rd_ptr_q [NCH];
  logic [AW:0]      rd_ptr_d [NCH];

  logic [NCH-1:0]   full;
  logic [NCH-1:0]   nonempty;
  logic [NCH-1:0]   push;
  logic [NCH-1:0]   pop;

  logic [TAGW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [TAGW-1:0]  gnt;
  logic             gnt_vld;
  logic             load;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [TAGW-1:0]  tag_q, tag_d;

  function automatic logic [TAGW-1:0] rr_idx(input logic [TAGW-1:0] base, input int k);
    return TAGW'((int'(base) + k) % NCH);
  endfunction

  // Ready depends only on occupancy, so a full FIFO stays not-ready even if it pops this cycle.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      full[i]     = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                    (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
      nonempty[i] = (wr_ptr_q[i] != rd_ptr_q[i]);
    end
  end

  assign in_enq__RDY = ~full;
  assign push        = in_enq__ENA & ~full;

  // Scan from the far end so the closest non-empty channel to rr_ptr_q wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (nonempty[rr_idx(rr_ptr_q, k)]) begin
        gnt     = rr_idx(rr_ptr_q, k);
        gnt_vld = 1'b1;
      end
    end
  end

  assign load = (!valid_q || out_enq__RDY) && gnt_vld;

  always_comb begin
    pop = '0;
    if (load) pop[gnt] = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + {{AW{1'b0}}, push[i]};
      rd_ptr_d[i] = rd_ptr_q[i] + {{AW{1'b0}}, pop[i]};
    end
  end

  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    tag_d    = tag_q;
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      valid_d  = 1'b1;
      data_d   = mem_q[gnt][rd_ptr_q[gnt][AW-1:0]];
      tag_d    = gnt;
      rr_ptr_d = (int'(gnt) == NCH - 1) ? '0 : gnt + 1'b1;
    end else if (out_enq__RDY) begin
      valid_d = 1'b0;
    end
  end

  // Storage carries no reset; validity is defined entirely by the pointers.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCH; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i][AW-1:0]] <= in_enq_v[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      rr_ptr_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      tag_q    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
    end
  end

  assign out_enq__ENA = valid_q;
  assign out_enq_v    = data_q;
  assign out_enq_tag  = tag_q;

`ifdef FUNNEL_COUNT_EN
  logic [15:0] cnt_q [NCH];
  logic [15:0] cnt_d [NCH];

  // A pop is exactly a load of that channel into the output register.
  always_comb begin
    for (int i = 0; i < NCH; i++) cnt_d[i] = cnt_q[i] + {15'd0, pop[i]};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign cnt_value = (int'(cnt_sel) < NCH) ? cnt_q[cnt_sel] : '0;
`endif

endmodule

// File: tb/tb_funnel_rr_buffered.sv
// Directed scoreboard bench for funnel_rr_buffered (NCH=4, DEPTH=4, WIDTH=32).
// Counter checks run only when FUNNEL_COUNT_EN is defined.
module tb_funnel_rr_buffered;

  logic         CLK;
  logic         nRST;
  logic [3:0]   in_ena;
  logic [127:0] in_v;
  logic [3:0]   in_rdy;
  logic         out_ena;
  logic [31:0]  out_v;
  logic [1:0]   out_tag;
  logic         out_rdy;
`ifdef FUNNEL_COUNT_EN
  logic [1:0]   cnt_sel;
  logic [15:0]  cnt_value;
`endif

  funnel_rr_buffered #(.WIDTH(32), .NCH(4), .DEPTH(4)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .in_enq__ENA  (in_ena),
    .in_enq_v     (in_v),
    .in_enq__RDY  (in_rdy),
    .out_enq__ENA (out_ena),
    .out_enq_v    (out_v),
    .out_enq_tag  (out_tag),
    .out_enq__RDY (out_rdy)
`ifdef FUNNEL_COUNT_EN
    ,
    .cnt_sel      (cnt_sel),
    .cnt_value    (cnt_value)
`endif
  );

  typedef struct packed {
    logic [1:0]  tag;
    logic [31:0] data;
  } beat_t;

  beat_t      sb[$];
  logic [1:0] tag_log[$];
  int         errs;
  int         checks;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Called at posedge+1: score any output handshake, record accepted inputs, advance one cycle.
  task automatic cycle();
    int    idx;
    beat_t b;
    if (out_ena && out_rdy) begin
      idx = -1;
      for (int j = 0; j < sb.size(); j++)
        if (idx < 0 && sb[j].tag == out_tag) idx = j;
      chk("sb_match_tag", {63'd0, idx >= 0}, 64'd1);
      if (idx >= 0) begin
        chk("sb_data", {32'd0, out_v}, {32'd0, sb[idx].data});
        sb.delete(idx);
      end
      tag_log.push_back(out_tag);
    end
    for (int i = 0; i < 4; i++) begin
      if (in_ena[i] && in_rdy[i]) begin
        b.tag  = i[1:0];
        b.data = in_v[i*32 +: 32];
        sb.push_back(b);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_dut();
    nRST   = 1'b0;
    in_ena = '0;
    sb.delete();
    tag_log.delete();
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    errs    = 0;
    checks  = 0;
    in_ena  = '0;
    in_v    = '0;
    out_rdy = 1'b1;
    nRST    = 1'b0;
`ifdef FUNNEL_COUNT_EN
    cnt_sel = '0;
`endif
    #2;
    chk("rst_ena_low", {63'd0, out_ena}, 64'd0);
    reset_dut();
    chk("rst_rdy_all", {60'd0, in_rdy}, 64'hF);
    chk("rst_ena", {63'd0, out_ena}, 64'd0);
    chk("rst_data", {32'd0, out_v}, 64'd0);
    chk("rst_tag", {62'd0, out_tag}, 64'd0);

    // Single beat on ch2: visible two cycles after the enq cycle.
    in_ena = 4'b0100;
    in_v[2*32 +: 32] = 32'hDEADBEEF;
    cycle();
    in_ena = '0;
    chk("lat_t1_ena", {63'd0, out_ena}, 64'd0);
    cycle();
    chk("lat_t2_ena", {63'd0, out_ena}, 64'd1);
    chk("lat_t2_data", {32'd0, out_v}, 64'hDEADBEEF);
    chk("lat_t2_tag", {62'd0, out_tag}, 64'd2);
    cycle();
    chk("single_drained", {63'd0, out_ena}, 64'd0);
    chk("single_sb_empty", 64'(sb.size()), 64'd0);

    // Fairness: two beats per channel, then drain at full rate.
    reset_dut();
    out_rdy = 1'b0;
    in_ena  = 4'hF;
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < 4; c++) in_v[c*32 +: 32] = 32'hA000_0000 | (c << 8) | b;
      cycle();
    end
    in_ena = '0;
    tag_log.delete();
    out_rdy = 1'b1;
    repeat (8) cycle();
    chk("fair_count", 64'(tag_log.size()), 64'd8);
    for (int k = 0; k < 8; k++)
      if (k < tag_log.size()) chk("fair_tag", {62'd0, tag_log[k]}, 64'(k % 4));
    chk("fair_idle", {63'd0, out_ena}, 64'd0);
    chk("fair_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure: output reg takes beat 0, FIFO fills with beats 1..4, beat 5 is refused.
    reset_dut();
    out_rdy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_ena = 4'b0001;
      in_v[31:0] = 32'h100 + k;
      chk("bp_rdy", {63'd0, in_rdy[0]}, {63'd0, k < 5});
      cycle();
      if (k >= 1) begin
        chk("bp_hold_ena", {63'd0, out_ena}, 64'd1);
        chk("bp_hold_data", {32'd0, out_v}, 64'h100);
        chk("bp_hold_tag", {62'd0, out_tag}, 64'd0);
      end
    end
    in_ena = '0;
    chk("bp_full_rdy", {63'd0, in_rdy[0]}, 64'd0);
    tag_log.delete();
    out_rdy = 1'b1;
    repeat (7) cycle();
    chk("bp_drain_count", 64'(tag_log.size()), 64'd5);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);
    chk("bp_rdy_back", {60'd0, in_rdy}, 64'hF);

    // Pointer wrap on ch1 with irregular draining.
    tag_log.delete();
    for (int k = 0; k < 10; k++) begin
      in_ena = 4'b0010;
      in_v[1*32 +: 32] = 32'h200 + k;
      out_rdy = (k % 3 != 0);
      cycle();
      in_ena = '0;
      cycle();
    end
    out_rdy = 1'b1;
    repeat (4) cycle();
    chk("wrap_count", 64'(tag_log.size()), 64'd10);
    chk("wrap_sb_empty", 64'(sb.size()), 64'd0);

    // Reset in the middle of traffic: nothing stale may come out afterwards.
    out_rdy = 1'b0;
    in_ena  = 4'hF;
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < 4; c++) in_v[c*32 +: 32] = 32'hC000_0000 | (c << 8) | b;
      cycle();
    end
    chk("mid_loaded_ena", {63'd0, out_ena}, 64'd1);
    #3;
    nRST = 1'b0;
    in_ena = '0;
    #1;
    chk("mid_async_ena", {63'd0, out_ena}, 64'd0);
    chk("mid_async_data", {32'd0, out_v}, 64'd0);
    sb.delete();
    tag_log.delete();
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    chk("mid_rel_rdy", {60'd0, in_rdy}, 64'hF);
    chk("mid_rel_ena", {63'd0, out_ena}, 64'd0);
    out_rdy = 1'b1;
    repeat (5) cycle();
    chk("mid_no_stale", 64'(tag_log.size()), 64'd0);

`ifdef FUNNEL_COUNT_EN
    reset_dut();
    out_rdy = 1'b1;
    in_ena  = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      in_v[31:0] = 32'h300 + k;
      cycle();
    end
    in_ena = 4'b1000;
    for (int k = 0; k < 70000; k++) begin
      in_v[3*32 +: 32] = k;
      cycle();
    end
    in_ena = '0;
    repeat (6) cycle();
    chk("cnt_sb_empty", 64'(sb.size()), 64'd0);
    cnt_sel = 2'd0;
    #1;
    chk("cnt_ch0", {48'd0, cnt_value}, 64'd3);
    cnt_sel = 2'd3;
    #1;
    chk("cnt_ch3", {48'd0, cnt_value}, 64'd4464);
    cnt_sel = 2'd1;
    #1;
    chk("cnt_ch1", {48'd0, cnt_value}, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
